// File: rtl/alu_serial_seq_if.sv
// Request/response bundle between a requester and the bit-serial ALU sequencer.
// Master drives the operands and the start strobe. Slave returns busy, done, result and cout.
// N sets the operand and result width and must match the sequencer's N.
interface alu_serial_seq_if #(
    parameter int N = 64
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [1:0]   op;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;

    modport master (
        output start, a, b, cin, op,
        input  busy, done, result, cout
    );

    modport slave (
        input  start, a, b, cin, op,
        output busy, done, result, cout
    );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: a single 1-bit cell is reused N times, LSB first, with the carry registered between bits.
// Latency: the request is accepted on E0, and done pulses after edge E(N). One operation every N+2 cycles.
// Backpressure: start is ignored while busy=1. Nothing is queued, so the requester holds or re-asserts start.

// One-bit ALU cell. op: 00 NOR, 01 XOR, 10 ADD, 11 SUB (b inverted).
// The cell always produces the full-adder carry so that the sequencer can chain it without decoding op.
module alu1bit #(
    parameter int nand_tpd = 0,
    parameter int or_tpd   = 0,
    parameter int xnor_tpd = 0
) (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       s,
    output logic       cout
);
    // This is a zero-delay model. The gate delays only bound the usable clock period.
    localparam bit TPD_VALID = (nand_tpd >= 0) && (or_tpd >= 0) && (xnor_tpd >= 0);
    if (!TPD_VALID) begin : g_tpd_invalid
    end

    logic bb;

    // Decode the result bit, and produce the adder carry for all ops.
    always_comb begin
        bb   = b ^ (op == 2'b11);
        s    = 1'b0;
        case (op)
            2'b00:   s = ~(a | b);
            2'b01:   s = a ^ b;
            default: s = a ^ bb ^ cin;
        endcase
        cout = (a & bb) | (a & cin) | (bb & cin);
    end
endmodule

module alu_serial_seq #(
    parameter int N        = 64,
    parameter int nand_tpd = 0,
    parameter int or_tpd   = 0,
    parameter int xnor_tpd = 0
) (
    input  logic            clk,
    input  logic            rst,
    alu_serial_seq_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          carry_q,  carry_d;
    logic [N-1:0]  a_sh_q,   a_sh_d;
    logic [N-1:0]  b_sh_q,   b_sh_d;
    logic [N-1:0]  acc_q,    acc_d;
    logic [1:0]    op_q,     op_d;
    logic [N-1:0]  result_q, result_d;
    logic          cout_q,   cout_d;

    logic cell_s;
    logic cell_cout;

    alu1bit #(
        .nand_tpd (nand_tpd),
        .or_tpd   (or_tpd),
        .xnor_tpd (xnor_tpd)
    ) u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .op   (op_q),
        .s    (cell_s),
        .cout (cell_cout)
    );

    // Next-state logic. One bit is consumed per RUN cycle. result and cout load only on the final bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        op_d     = op_q;
        result_d = result_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    op_d    = bus.op;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = cell_cout;
                acc_d   = {cell_s, acc_q[N-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    result_d = {cell_s, acc_q[N-1:1]};
                    cout_d   = cell_cout;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            op_q     <= 2'b00;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
endmodule
